// File: rtl/instr_reorder_buf.sv
// Issue-side reorder buffer: holds decoded entries in age order and lets a hazard-free
// younger ALU-type op overtake a load/store stalled on a busy LSU, bounded by a starvation limit.
package ariane_pkg;
    typedef enum logic [3:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU
    } fu_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] cause;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        exception_t  ex;
    } scoreboard_entry_t;
endpackage

module instr_reorder_buf import ariane_pkg::*; #(
    parameter int DEPTH      = 4,
    parameter bit BYPASS_EN  = 1'b1,
    parameter int MAX_BYPASS = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         debug_req_i,
    input  scoreboard_entry_t            issue_entry_i,
    input  logic                         issue_entry_valid_i,
    input  logic                         is_ctrl_flow_i,
    output logic                         issue_instr_ack_o,
    output scoreboard_entry_t            issue_entry_o,
    output logic                         issue_entry_valid_o,
    output logic                         is_ctrl_flow_o,
    input  logic                         issue_instr_ack_i,
    input  logic                         lsu_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    scoreboard_entry_t ent_q [DEPTH];
    scoreboard_entry_t ent_n [DEPTH];
    logic [DEPTH-1:0]  ctrl_q, ctrl_n;
    logic [CW-1:0]     cnt_q, cnt_n, cnt_tmp;
    logic [CW-1:0]     byp_q, byp_n;
    logic [IW-1:0]     sel;
    logic              empty, full, can_byp, pop, pop_st, push, store;

    function automatic logic is_mem(input scoreboard_entry_t e);
        return (e.fu == LOAD) || (e.fu == STORE);
    endfunction

    // Entries that nothing younger may pass: control flow, faulting, CSR.
    function automatic logic is_barrier(input scoreboard_entry_t e, input logic c);
        return c || e.ex.valid || (e.fu == CSR);
    endfunction

    // Register indices only; int/fp files are not distinguished, so this errs safe.
    function automatic logic hazard(input scoreboard_entry_t o, input scoreboard_entry_t y);
        return (y.rs1 == o.rd) || (y.rs2 == o.rd) ||
               (y.rd == o.rs1) || (y.rd == o.rs2) || (y.rd == o.rd);
    endfunction

    assign empty             = (cnt_q == '0);
    assign full              = (cnt_q == CW'(DEPTH));
    assign issue_instr_ack_o = !full && !flush_i;
    assign occupancy_o       = cnt_q;

    assign can_byp = BYPASS_EN && !debug_req_i && !empty && is_mem(ent_q[0]) &&
                     !lsu_ready_i && (byp_q < CW'(MAX_BYPASS));

    always_comb begin
        logic ok;
        logic found;
        sel   = '0;
        found = 1'b0;
        ok    = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            ok = (k < int'(cnt_q)) && !is_mem(ent_q[k]) &&
                 !is_barrier(ent_q[k], ctrl_q[k]);
            for (int j = 0; j < k; j++) begin
                if (is_barrier(ent_q[j], ctrl_q[j]) || hazard(ent_q[j], ent_q[k]))
                    ok = 1'b0;
            end
            if (can_byp && ok && !found) begin
                sel   = IW'(k);
                found = 1'b1;
            end
        end
    end

    // An empty buffer forwards the input so a ready issue stage sees zero latency.
    always_comb begin
        issue_entry_o       = '0;
        is_ctrl_flow_o      = 1'b0;
        issue_entry_valid_o = 1'b0;
        if (empty) begin
            if (issue_entry_valid_i) begin
                issue_entry_o       = issue_entry_i;
                is_ctrl_flow_o      = is_ctrl_flow_i;
                issue_entry_valid_o = 1'b1;
            end
        end else begin
            issue_entry_o       = ent_q[sel];
            is_ctrl_flow_o      = ctrl_q[sel];
            issue_entry_valid_o = 1'b1;
        end
    end

    assign pop    = issue_entry_valid_o && issue_instr_ack_i && !flush_i;
    assign pop_st = pop && !empty;
    assign push   = issue_entry_valid_i && issue_instr_ack_o;
    assign store  = push && !(empty && pop);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_n[i] = ent_q[i];
        ctrl_n  = ctrl_q;
        cnt_tmp = cnt_q - CW'(pop_st);
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop_st && (i >= int'(sel))) begin
                ent_n[i]  = ent_q[i+1];
                ctrl_n[i] = ctrl_q[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (store && (i == int'(cnt_tmp))) begin
                ent_n[i]  = issue_entry_i;
                ctrl_n[i] = is_ctrl_flow_i;
            end
        end
        cnt_n = cnt_tmp + CW'(store);
        byp_n = byp_q;
        if (pop) byp_n = (sel == '0) ? '0 : byp_q + CW'(1);
        if (flush_i) begin
            cnt_n = '0;
            byp_n = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            ctrl_q <= '0;
            cnt_q  <= '0;
            byp_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
            ctrl_q <= ctrl_n;
            cnt_q  <= cnt_n;
            byp_q  <= byp_n;
        end
    end
endmodule

// File: doc/instr_reorder_buf.md
Name: instr_reorder_buf

Overview:
- Parametrised issue-side reorder buffer between the decoder/issue-queue output and the issue stage.
- Holds up to DEPTH decoded scoreboard entries in age order.
- Normally issues oldest-first. While the LSU is busy, it lets a hazard-free younger non-memory instruction overtake a stalled load/store, so back-to-back memory ops are spread out.
- A starvation limit bounds how long the held memory op waits.

Parameters:
- DEPTH, 4: buffer entries (2..8).
- BYPASS_EN, 1: 0 = strict in-order FIFO, no overtaking.
- MAX_BYPASS, 3: maximum consecutive overtakes of one head entry (1..DEPTH-1).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; drop all held entries
- debug_req_i  in  1  high: overtaking disabled (strict in-order)
- issue_entry_i  in  ariane_pkg::scoreboard_entry_t  decoded entry from decoder
- issue_entry_valid_i  in  1  issue_entry_i valid
- is_ctrl_flow_i  in  1  entry is branch/jump
- issue_instr_ack_o  out  1  entry accepted this cycle (push = valid_i & ack_o)
- issue_entry_o  out  ariane_pkg::scoreboard_entry_t  selected entry to issue stage
- issue_entry_valid_o  out  1  issue_entry_o valid
- is_ctrl_flow_o  out  1  selected entry is control flow
- issue_instr_ack_i  in  1  issue stage consumed selected entry (pop)
- lsu_ready_i  in  1  LSU can accept a memory op
- occupancy_o  out  $clog2(DEPTH+1)  entries held (registered)

Behaviour:

Reset (async, rst_ni=0):
- All entries invalid; bypass counter 0.
- Outputs: issue_entry_valid_o=0, issue_entry_o='0, is_ctrl_flow_o=0, occupancy_o=0, issue_instr_ack_o=1.

Storage:
- Age-ordered array. Slot 0 is the head (oldest).
- A pop from slot k shifts slots k+1..N-1 down by one in the same edge.
- A simultaneous push lands at the first free slot after the shift.

Accept:
- issue_instr_ack_o = !full & !flush_i, where full means occupancy==DEPTH.
- It does not depend on issue_instr_ack_i, so there is no combinational loop.

Pass-through (zero latency):
- When the buffer is empty and issue_entry_valid_i=1, the input is presented directly on the outputs.
- If issue_instr_ack_i=1 in that cycle, the entry is not stored.

Selection, evaluated each cycle:
- A memory op is an entry with fu==LOAD or fu==STORE.
- Default selection is the head.
- Overtake is allowed only when all of these hold: BYPASS_EN=1, !debug_req_i, head is a memory op, lsu_ready_i=0, bypass_cnt<MAX_BYPASS.
- When allowed, select the oldest slot k>0 that meets all of these:
  - not a memory op
  - not control flow
  - ex.valid=0
  - fu!=CSR
  - no older slot j<k is control flow, ex.valid, or CSR
  - no hazard against any slot j<k
- Hazard definition, compared on register index only, int/fp not distinguished (conservative):
  - RAW: rs1/rs2 of k equals rd of j
  - WAR: rd of k equals rs1/rs2 of j
  - WAW: rd of k equals rd of j
- If no candidate qualifies, the head is presented.

Bypass counter:
- +1 on each pop of a non-head slot.
- Cleared on head pop, on flush, and on reset.
- At MAX_BYPASS only the head may issue, so it waits for lsu_ready_i.

Flush:
- In the flush_i cycle the outputs still reflect current state, but the input is not accepted and pops are ignored.
- On the next edge all entries are invalidated and bypass_cnt=0.

Boundaries:
- Full and pop in the same cycle: no push that cycle (ack_o was 0).
- Empty and no input: issue_entry_valid_o=0.
- DEPTH=1 or BYPASS_EN=0 degenerates to an in-order skid buffer.

Test Plan:
1. Reset mid-operation with 3 entries held -> next cycle occupancy_o=0, issue_entry_valid_o=0, issue_instr_ack_o=1.
2. Empty buffer, push ADD with issue_instr_ack_i=1 -> ADD on issue_entry_o the same cycle; occupancy stays 0.
3. Held LW x5 then ADD x6,x7,x8, lsu_ready_i=0 -> ADD issued first, bypass_cnt=1. Then lsu_ready_i=1 -> LW issued, bypass_cnt=0.
4. Held LW x5 then ADD x6,x5,x1 (RAW), lsu_ready_i=0 -> LW stays presented, no overtake. Same with BEQ held between LW and ADD -> no overtake.
5. MAX_BYPASS=3: LW at head plus 4 independent ALU ops, lsu_ready_i=0 -> exactly 3 ALU ops issue, then LW is presented until lsu_ready_i=1.
6. DEPTH=4 full, flush_i=1 with issue_entry_valid_i=1 -> issue_instr_ack_o=0 that cycle; next cycle occupancy_o=0. debug_req_i=1 with LW at head and lsu_ready_i=0 -> head held, nothing overtakes.
